// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter unit.
//   pc_state_t      : FSM states (BOOT, RUN, HOLD)
//   INSTR_BYTES     : sequential step size in bytes
//   redir_sel_t     : which source supplies the next redirect target
//   redirect_select : redirect priority encoder (trap > flush > pending)
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_PEND  = 2'd1,
        SEL_FLUSH = 2'd2,
        SEL_TRAP  = 2'd3
    } redir_sel_t;

    // A trap always wins. A flush wins unless a trap is already pending.
    // The held entry is only a candidate while the unit is holding one.
    function automatic redir_sel_t redirect_select(
        input logic trap_req,
        input logic flush_req,
        input logic pend_is_trap,
        input logic holding
    );
        redir_sel_t sel;
        if (trap_req) begin
            sel = SEL_TRAP;
        end else if (flush_req && !pend_is_trap) begin
            sel = SEL_FLUSH;
        end else if (holding) begin
            sel = SEL_PEND;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// ---------------------------------------------------------------------------
// pc_redirect_hold
// Holds a redirect that arrived while the PC was stalled, and merges it with
// same-cycle redirect requests.
// Ports:
//   clk, reset      : clock, async active-high reset
//   active          : unit is out of BOOT (redirects are honoured)
//   holding         : unit is in HOLD (a pending entry is valid)
//   enable          : 0 = stall; the pending entry is captured/updated
//                     1 = release; the pending entry is consumed
//   trap_valid/target  : trap request, target already normalised
//   flush_ok/target    : acceptable flush request, target normalised
//   sel             : winning redirect source for this cycle
//   merge_target    : address of the winning source
//   pend_is_trap    : registered flag, pending entry came from a trap
// ---------------------------------------------------------------------------
module pc_redirect_hold
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            active,
    input  logic            holding,
    input  logic            enable,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            flush_ok,
    input  logic [XLEN-1:0] flush_target,
    output redir_sel_t      sel,
    output logic [XLEN-1:0] merge_target,
    output logic            pend_is_trap
);

    logic [XLEN-1:0] pend_target_r;
    logic            pend_is_trap_r;
    redir_sel_t      sel_s;
    logic [XLEN-1:0] merge_target_s;

    // Priority selection; BOOT ignores every request.
    always_comb begin
        sel_s = SEL_NONE;
        if (active) begin
            sel_s = redirect_select(trap_valid, flush_ok, pend_is_trap_r, holding);
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Target of the winning source.
    always_comb begin
        merge_target_s = pend_target_r;
        case (sel_s)
            SEL_TRAP:  merge_target_s = trap_target;
            SEL_FLUSH: merge_target_s = flush_target;
            SEL_PEND:  merge_target_s = pend_target_r;
            default:   merge_target_s = pend_target_r;
        endcase
    end

    // Pending entry: loaded by the winner while stalled, cleared on release.
    // Clearing on release keeps pend_is_trap at 0 while in RUN so a plain
    // stall capture uses the same trap-over-flush rule.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_target_r  <= '0;
            pend_is_trap_r <= 1'b0;
        end else if (active && holding && enable) begin
            pend_target_r  <= '0;
            pend_is_trap_r <= 1'b0;
        end else if (active && !enable) begin
            case (sel_s)
                SEL_TRAP: begin
                    pend_target_r  <= trap_target;
                    pend_is_trap_r <= 1'b1;
                end
                SEL_FLUSH: begin
                    pend_target_r  <= flush_target;
                    pend_is_trap_r <= 1'b0;
                end
                default: begin
                    pend_target_r  <= pend_target_r;
                    pend_is_trap_r <= pend_is_trap_r;
                end
            endcase
        end else begin
            pend_target_r  <= pend_target_r;
            pend_is_trap_r <= pend_is_trap_r;
        end
    end

    assign sel          = sel_s;
    assign merge_target = merge_target_s;
    assign pend_is_trap = pend_is_trap_r;

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter at the head of IF. Steps by INSTR_BYTES, stalls on
// enable = 0 and applies trap / branch redirects. A redirect arriving during
// a stall is held and applied when the stall releases.
// Configuration macro: PC_MISALIGN_CHECK_EN
//   defined   : targets have bit 0 cleared; a flush target with bit 1 set is
//               rejected (PC and pending entry unchanged, misalign_fault pulses)
//   undefined : targets have bits [1:0] cleared; misalign_fault stays 0
// Ports:
//   clk, reset                : clock, async active-high reset
//   enable                    : 0 = stall
//   trap_valid, trap_target   : trap redirect (highest priority)
//   flush_valid, flush_target : EX branch/jump redirect
//   pc_out                    : fetch address (registered)
//   pc_plus4                  : pc_out + 4 (combinational, wraps)
//   pc_valid                  : pc_out is fetchable (registered)
//   redirect_pending          : a redirect is held (registered)
//   misalign_fault            : one-cycle rejected-flush pulse (registered)
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_target,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            misalign_fault
);

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
`ifdef PC_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] TGT_MASK = ~(XLEN'(2'b01));
`else
    localparam logic [XLEN-1:0] TGT_MASK = ~(XLEN'(2'b11));
`endif

    pc_state_t       state_r;
    pc_state_t       state_n_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_n_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic            pc_valid_r;
    logic            pending_r;
    logic            fault_r;
    logic            fault_n_s;
    logic [XLEN-1:0] trap_tgt_s;
    logic [XLEN-1:0] flush_tgt_s;
    logic            flush_bad_s;
    logic            flush_ok_s;
    logic            active_s;
    logic            holding_s;
    redir_sel_t      sel_s;
    logic [XLEN-1:0] merge_target_s;
    logic            pend_is_trap_s;

    // Target normalisation and flush alignment screening.
    always_comb begin
        trap_tgt_s  = trap_target & TGT_MASK;
        flush_tgt_s = flush_target & TGT_MASK;
`ifdef PC_MISALIGN_CHECK_EN
        flush_bad_s = flush_target[1];
`else
        flush_bad_s = 1'b0;
`endif
        flush_ok_s  = flush_valid && !flush_bad_s;
        active_s    = (state_r != BOOT);
        holding_s   = (state_r == HOLD);
        pc_plus4_s  = pc_r + STEP;
    end

    pc_redirect_hold #(
        .XLEN(XLEN)
    ) u_hold (
        .clk          (clk),
        .reset        (reset),
        .active       (active_s),
        .holding      (holding_s),
        .enable       (enable),
        .trap_valid   (trap_valid),
        .trap_target  (trap_tgt_s),
        .flush_ok     (flush_ok_s),
        .flush_target (flush_tgt_s),
        .sel          (sel_s),
        .merge_target (merge_target_s),
        .pend_is_trap (pend_is_trap_s)
    );

    // Next state, next PC and fault pulse.
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        // A misaligned flush faults only when it would have won arbitration.
        fault_n_s = active_s && flush_valid && flush_bad_s &&
                    !trap_valid && !pend_is_trap_s;
        case (state_r)
            BOOT: begin
                state_n_s = RUN;
            end
            RUN: begin
                if (enable) begin
                    if (sel_s == SEL_NONE) begin
                        pc_n_s = pc_plus4_s;
                    end else begin
                        pc_n_s = merge_target_s;
                    end
                end else if (sel_s != SEL_NONE) begin
                    state_n_s = HOLD;
                end else begin
                    state_n_s = RUN;
                end
            end
            HOLD: begin
                if (enable) begin
                    pc_n_s    = merge_target_s;
                    state_n_s = RUN;
                end else begin
                    state_n_s = HOLD;
                end
            end
            default: begin
                state_n_s = BOOT;
                pc_n_s    = RESET_PC;
            end
        endcase
    end

    // State, PC and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= BOOT;
            pc_r       <= RESET_PC;
            pc_valid_r <= 1'b0;
            pending_r  <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            pc_r       <= pc_n_s;
            pc_valid_r <= 1'b1;
            pending_r  <= (state_n_s == HOLD);
            fault_r    <= fault_n_s;
        end
    end

    assign pc_out           = pc_r;
    assign pc_plus4         = pc_plus4_s;
    assign pc_valid         = pc_valid_r;
    assign redirect_pending = pending_r;
    assign misalign_fault   = fault_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural model of the PC/pending-redirect rules.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
`ifdef PC_MISALIGN_CHECK_EN
    localparam bit          CHECK_EN = 1'b1;
    localparam logic [31:0] MASK     = 32'hFFFF_FFFE;
`else
    localparam bit          CHECK_EN = 1'b0;
    localparam logic [31:0] MASK     = 32'hFFFF_FFFC;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect_pending;
    logic        misalign_fault;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_booted;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    bit          m_pend_trap;
    bit          m_fault;

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .trap_valid       (trap_valid),
        .trap_target      (trap_target),
        .flush_valid      (flush_valid),
        .flush_target     (flush_target),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .misalign_fault   (misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booted    = 1'b0;
        m_pc        = RV;
        m_valid     = 1'b0;
        m_pend      = 1'b0;
        m_pend_tgt  = 32'h0;
        m_pend_trap = 1'b0;
        m_fault     = 1'b0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_edge();
        logic [31:0] t, f;
        bit fbad, fl, trap_held;
        m_fault = 1'b0;
        if (!m_booted) begin
            m_booted = 1'b1;
            m_valid  = 1'b1;
        end else begin
            t         = trap_target & MASK;
            f         = flush_target & MASK;
            fbad      = CHECK_EN && flush_target[1];
            trap_held = m_pend && m_pend_trap;
            if (flush_valid && fbad && !trap_valid && !trap_held) m_fault = 1'b1;
            fl = flush_valid && !fbad;
            if (enable) begin
                if (trap_valid)              m_pc = t;
                else if (fl && !trap_held)   m_pc = f;
                else if (m_pend)             m_pc = m_pend_tgt;
                else                         m_pc = m_pc + 32'd4;
                m_pend = 1'b0; m_pend_tgt = 32'h0; m_pend_trap = 1'b0;
            end else if (trap_valid) begin
                m_pend = 1'b1; m_pend_tgt = t; m_pend_trap = 1'b1;
            end else if (fl && !trap_held) begin
                m_pend = 1'b1; m_pend_tgt = f; m_pend_trap = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        check_eq("pc_out", pc_out, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        check_eq("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        check_eq("misalign_fault", {31'd0, misalign_fault}, {31'd0, m_fault});
    endtask

    // Apply inputs (called at a falling edge), take one rising edge, check.
    task automatic step(input bit en, input bit tv, input logic [31:0] tt,
                        input bit fv, input logic [31:0] ft);
        enable = en; trap_valid = tv; trap_target = tt;
        flush_valid = fv; flush_target = ft;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; trap_valid = 1'b0; flush_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_model();
    endtask

    // Asynchronous reset raised between edges: outputs must clear at once.
    task automatic mid_cycle_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_pc", pc_out, RV);
        check_eq("async_rst_pend", {31'd0, redirect_pending}, 32'd0);
        check_eq("async_rst_valid", {31'd0, pc_valid}, 32'd0);
        do_reset();
    endtask

    initial begin
        do_reset();
        check_eq("boot_pc0", pc_out, 32'h0);
        check_eq("boot_valid0", {31'd0, pc_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("boot_pc1", pc_out, 32'h0);
        check_eq("boot_valid1", {31'd0, pc_valid}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("seq_pc2", pc_out, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("seq_pc3", pc_out, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("seq_pc4", pc_out, 32'hC);

        // Trap beats flush in the same cycle
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
        step(1'b1, 1'b1, 32'h80, 1'b1, 32'h200);
        check_eq("trap_over_flush", pc_out, 32'h80);

        // Flush during a stall is held and applied on release
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        check_eq("stall_pend", {31'd0, redirect_pending}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            check_eq("stall_pc", pc_out, 32'h40);
            check_eq("stall_pend_hold", {31'd0, redirect_pending}, 32'd1);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("release_pc", pc_out, 32'h300);
        check_eq("release_pend", {31'd0, redirect_pending}, 32'd0);

        // Pending trap is not displaced by a later flush
        step(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("pend_trap_wins", pc_out, 32'h80);

        // Wrap at the top of the address space
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        check_eq("plus4_wrap", pc_plus4, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("pc_wrap", pc_out, 32'h0);

        // Misaligned flush target
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h102);
        if (CHECK_EN) begin
            check_eq("misalign_pc", pc_out, 32'h24);
            check_eq("misalign_fault", {31'd0, misalign_fault}, 32'd1);
        end else begin
            check_eq("misalign_pc", pc_out, 32'h100);
            check_eq("misalign_fault", {31'd0, misalign_fault}, 32'd0);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("fault_one_cycle", {31'd0, misalign_fault}, 32'd0);

        // Reset while holding a redirect
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h700);
        check_eq("hold_before_rst", {31'd0, redirect_pending}, 32'd1);
        mid_cycle_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] tt, ft;
            bit en, tv, fv;
            en = ($urandom_range(99) < 65);
            tv = ($urandom_range(99) < 12);
            fv = ($urandom_range(99) < 30);
            tt = $urandom();
            ft = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom();
            if ($urandom_range(199) == 0) begin
                mid_cycle_reset();
            end else begin
                step(en, tv, tt, fv, ft);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
